// File: rtl/gray_step_decoder_pkg.sv
// Shared definitions for the Gray step decoder: Gray code points, FSM encodings,
// step classes and the Gray-to-binary helpers.
package gray_step_decoder_pkg;

  // Gray code points in up-count order
  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_FILL  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FAULT = 2'd2;

  // Class codes equal the modulo-4 binary difference, so classify() is a subtraction
  typedef logic [1:0] step_cls_t;
  localparam step_cls_t CLS_NONE    = 2'd0;
  localparam step_cls_t CLS_UP      = 2'd1;
  localparam step_cls_t CLS_ILLEGAL = 2'd2;
  localparam step_cls_t CLS_DOWN    = 2'd3;

  // FILL occupies fill counter values 0..FILL_LAST
  localparam logic [1:0] FILL_LAST = 2'd2;

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    logic [1:0] b;
    b = 2'd0;
    case (g)
      G0: b = 2'd0;
      G1: b = 2'd1;
      G2: b = 2'd2;
      G3: b = 2'd3;
      default: b = 2'd0;
    endcase
    return b;
  endfunction

  function automatic step_cls_t classify(input logic [1:0] cur_g, input logic [1:0] prev_g);
    logic [1:0] diff;
    diff = gray2bin(cur_g) - gray2bin(prev_g);
    return step_cls_t'(diff);
  endfunction

endpackage

// File: rtl/gray_sync2.sv
// Two-flop synchroniser for a vector that changes at most one bit at a time
// (Gray code), with synchronous reset.
module gray_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/gray_step_decoder.sv
// Decodes a synchronised 2-bit Gray stream into up/down steps, keeps a wrapping
// position count and flags illegal double-bit jumps (optionally halting in FAULT).
module gray_step_decoder #(
  parameter int CNT_W       = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       gray_in,
  input  logic             err_clr,
  input  logic             pos_load,
  input  logic [CNT_W-1:0] pos_val,
  output logic [CNT_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             wrap,
  output logic             err,
  output logic             ready,
  output logic [1:0]       bin_out
);

  import gray_step_decoder_pkg::*;

  localparam logic [CNT_W-1:0] POS_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] POS_MAX  = '1;
  localparam logic [CNT_W-1:0] POS_ZERO = '0;

  logic [1:0]       s2;
  logic [1:0]       prev_q;
  logic [1:0]       bin_q;
  state_t           state_q,    state_d;
  logic [1:0]       fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] pos_q,      pos_d;
  logic             step_q,     step_d;
  logic             dir_q,      dir_d;
  logic             wrap_q,     wrap_d;
  logic             err_q,      err_d;
  step_cls_t        cls;

  gray_sync2 #(.W(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gray_in),
    .q_o (s2)
  );

  always_comb begin
    cls        = classify(s2, prev_q);
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_FILL: begin
        // Wait until s1, s2 and prev all hold post-reset samples
        if (fill_cnt_q == FILL_LAST) begin
          state_d    = ST_RUN;
          fill_cnt_d = 2'd0;
        end else begin
          fill_cnt_d = fill_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (err_clr) begin
          err_d = 1'b0;
        end
        case (cls)
          CLS_NONE: ;
          CLS_UP: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + POS_ONE;
            wrap_d = (pos_q == POS_MAX);
          end
          CLS_DOWN: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - POS_ONE;
            wrap_d = (pos_q == POS_ZERO);
          end
          CLS_ILLEGAL: begin
            err_d = 1'b1;
            if (HALT_ON_ERR) begin
              state_d = ST_FAULT;
            end
          end
          default: ;
        endcase
      end
      ST_FAULT: begin
        if (err_clr) begin
          err_d      = 1'b0;
          state_d    = ST_FILL;
          fill_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d    = ST_FILL;
        fill_cnt_d = 2'd0;
      end
    endcase

    // A load overrides the count value but not the step/dir report
    if (pos_load) begin
      pos_d  = pos_val;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 2'b00;
      bin_q      <= 2'b00;
      state_q    <= ST_FILL;
      fill_cnt_q <= 2'd0;
      pos_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= s2;
      bin_q      <= gray2bin(s2);
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign pos     = pos_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign wrap    = wrap_q;
  assign err     = err_q;
  assign ready   = (state_q == ST_RUN);
  assign bin_out = bin_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Bench for gray_step_decoder: a halting and a non-halting instance share stimulus;
// step pulses of the halting instance are matched against a queue of expected results.
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic       pos_load;
  logic [1:0] gray_in;
  logic [7:0] pos_val;

  logic [7:0] pos1, pos0;
  logic       step1, step0, dir1, dir0, wrap1, wrap0, err1, err0, ready1, ready0;
  logic [1:0] bin1, bin0;

  always #5 clk = ~clk;

  gray_step_decoder #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .pos_load(pos_load), .pos_val(pos_val),
    .pos(pos1), .step(step1), .dir(dir1), .wrap(wrap1),
    .err(err1), .ready(ready1), .bin_out(bin1)
  );

  gray_step_decoder #(.CNT_W(8), .HALT_ON_ERR(1'b0)) dut_nohalt (
    .clk(clk), .rst(rst), .gray_in(gray_in), .err_clr(err_clr),
    .pos_load(pos_load), .pos_val(pos_val),
    .pos(pos0), .step(step0), .dir(dir0), .wrap(wrap0),
    .err(err0), .ready(ready0), .bin_out(bin0)
  );

  typedef struct packed {
    logic [7:0] pos;
    logic       dir;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [1:0] g;
    logic [7:0] pos;
    logic       dir;
    logic       wrap;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[11];
  logic [1:0] gseq[4];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] p, input logic d, input logic w);
    exp_t e;
    e.pos  = p;
    e.dir  = d;
    e.wrap = w;
    sb_q.push_back(e);
  endtask

  // One clock: check the step output of the halting instance mid-cycle, then
  // return 1ns after the next rising edge, where inputs are driven.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (rst === 1'b0) begin
      if (step1 === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_step: got step=1 pos=%0d want no step", pos1);
        end else begin
          e = sb_q.pop_front();
          $display("step observed: pos=%0d dir=%0b wrap=%0b", pos1, dir1, wrap1);
          chk("step_pos",  32'(pos1),  32'(e.pos));
          chk("step_dir",  32'(dir1),  32'(e.dir));
          chk("step_wrap", 32'(wrap1), 32'(e.wrap));
        end
      end else if (wrap1 === 1'b1) begin
        total++;
        bad++;
        $display("FAIL wrap_without_step: got wrap=1 want 0");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] g, input int n);
    gray_in = g;
    repeat (n) cyc();
  endtask

  task automatic drain();
    repeat (4) cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic [1:0] g);
    rst      = 1'b1;
    gray_in  = g;
    err_clr  = 1'b0;
    pos_load = 1'b0;
    pos_val  = 8'd0;
    cyc();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic fill_check(input bit both);
    for (int i = 0; i < 3; i++) begin
      chk("fill_ready_halt", 32'(ready1), 32'd0);
      if (both) chk("fill_ready_nohalt", 32'(ready0), 32'd0);
      cyc();
    end
    chk("run_ready_halt", 32'(ready1), 32'd1);
    chk("run_ready_nohalt", 32'(ready0), 32'd1);
  endtask

  task automatic zero_check();
    chk("rst_pos",   32'(pos1),  32'd0);
    chk("rst_step",  32'(step1), 32'd0);
    chk("rst_dir",   32'(dir1),  32'd0);
    chk("rst_wrap",  32'(wrap1), 32'd0);
    chk("rst_err",   32'(err1),  32'd0);
    chk("rst_ready", 32'(ready1), 32'd0);
    chk("rst_bin",   32'(bin1),  32'd0);
    chk("rst_pos_nh", 32'(pos0), 32'd0);
    chk("rst_err_nh", 32'(err0), 32'd0);
    chk("rst_dir_nh", 32'(dir0), 32'd0);
  endtask

  initial begin
    // Up sequence 00->01->11->10->00 twice, then down 00->10->11->01
    vecs[0]  = '{2'b01, 8'd1, 1'b1, 1'b0};
    vecs[1]  = '{2'b11, 8'd2, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 8'd3, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 8'd4, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 8'd5, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 8'd6, 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 8'd7, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 8'd8, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 8'd7, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 8'd6, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 8'd5, 1'b0, 1'b0};
    gseq[0] = 2'b00;
    gseq[1] = 2'b01;
    gseq[2] = 2'b11;
    gseq[3] = 2'b10;

    // Reset with gray_in at 10
    do_reset(2'b10);
    zero_check();
    fill_check(1'b1);
    chk("bin_out_10", 32'(bin1), 32'h3);
    chk("pos_after_fill", 32'(pos1), 32'd0);

    // Table: 8 up steps, then 3 down steps
    do_reset(2'b00);
    fill_check(1'b1);
    for (int i = 0; i < 11; i++) begin
      push_exp(vecs[i].pos, vecs[i].dir, vecs[i].wrap);
      apply(vecs[i].g, 2);
      if (i == 7) begin
        drain();
        chk("up8_pos", 32'(pos1), 32'd8);
        chk("up8_dir", 32'(dir1), 32'd1);
        chk("up8_err", 32'(err1), 32'd0);
        chk("up8_pos_nh", 32'(pos0), 32'd8);
      end
    end
    drain();
    chk("down3_pos", 32'(pos1), 32'd5);
    chk("down3_dir", 32'(dir1), 32'd0);
    chk("down3_pos_nh", 32'(pos0), 32'd5);

    // Load 255 then wrap up and back down
    pos_val  = 8'd255;
    pos_load = 1'b1;
    cyc();
    pos_load = 1'b0;
    chk("load_pos", 32'(pos1), 32'd255);
    chk("load_pos_nh", 32'(pos0), 32'd255);
    push_exp(8'd0, 1'b1, 1'b1);
    apply(2'b11, 2);
    drain();
    chk("wrap_up_pos", 32'(pos1), 32'd0);
    push_exp(8'd255, 1'b0, 1'b1);
    apply(2'b01, 2);
    drain();
    chk("wrap_dn_pos", 32'(pos1), 32'd255);

    // Load coincident with an up step from 255: load value wins, no wrap
    push_exp(8'd10, 1'b1, 1'b0);
    gray_in = 2'b11;
    cyc();
    cyc();
    pos_load = 1'b1;
    pos_val  = 8'd10;
    cyc();
    pos_load = 1'b0;
    drain();
    chk("load_step_pos", 32'(pos1), 32'd10);
    chk("load_step_pos_nh", 32'(pos0), 32'd10);
    chk("load_step_dir", 32'(dir1), 32'd1);

    // Illegal jump 11->00 with err_clr in the same cycle: set wins
    gray_in = 2'b00;
    cyc();
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ill_err_halt", 32'(err1), 32'd1);
    chk("ill_err_nohalt", 32'(err0), 32'd1);
    chk("ill_ready_halt", 32'(ready1), 32'd0);
    chk("ill_ready_nohalt", 32'(ready0), 32'd1);
    chk("ill_pos_halt", 32'(pos1), 32'd10);

    // Legal step while faulted: only the non-halting instance counts
    apply(2'b01, 2);
    drain();
    chk("fault_pos_halt", 32'(pos1), 32'd10);
    chk("fault_pos_nohalt", 32'(pos0), 32'd11);
    chk("fault_err_halt", 32'(err1), 32'd1);

    // Clear: FAULT -> FILL for 3 cycles -> RUN
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_err_halt", 32'(err1), 32'd0);
    chk("clr_err_nohalt", 32'(err0), 32'd0);
    fill_check(1'b0);
    push_exp(8'd11, 1'b1, 1'b0);
    apply(2'b11, 2);
    drain();
    chk("resume_pos_halt", 32'(pos1), 32'd11);
    chk("resume_pos_nohalt", 32'(pos0), 32'd12);

    // Reset at pos=37 with err set
    pos_val  = 8'd37;
    pos_load = 1'b1;
    cyc();
    pos_load = 1'b0;
    apply(2'b00, 2);
    drain();
    chk("pre_rst_err", 32'(err1), 32'd1);
    chk("pre_rst_pos", 32'(pos1), 32'd37);
    chk("pre_rst_err_nh", 32'(err0), 32'd1);
    do_reset(2'b10);
    zero_check();
    fill_check(1'b1);
    chk("post_rst_bin", 32'(bin1), 32'h3);

    // Upstream Gray counter advancing every cycle for 100 cycles
    for (int k = 0; k < 100; k++) begin
      push_exp(8'(k + 1), 1'b1, 1'b0);
      gray_in = gseq[(k + 0) % 4];
      cyc();
    end
    drain();
    chk("chain_pos", 32'(pos1), 32'd100);
    chk("chain_pos_nh", 32'(pos0), 32'd100);
    chk("chain_err", 32'(err1), 32'd0);
    chk("chain_err_nh", 32'(err0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
